// File: rtl/alu_issue.sv
// Issue/collect stage around the combinational ALU. A 2-entry FIFO feeds the ALU and a
// registered result goes to writeback. Illegal op codes are dropped and raise an abort pulse.
module alu_issue #(
    parameter int XLEN   = 32,
    parameter int ALUC_W = 5,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ALUC_W-1:0] in_aluc,
    input  logic [XLEN-1:0]   in_num1,
    input  logic [XLEN-1:0]   in_num2,
    input  logic [RD_W-1:0]   in_rd,
    output logic [ALUC_W-1:0] alu_aluc,
    output logic [XLEN-1:0]   alu_num1,
    output logic [XLEN-1:0]   alu_num2,
    input  logic [XLEN-1:0]   alu_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic [RD_W-1:0]   out_rd,
    output logic              abort,
    output logic [ALUC_W-1:0] abort_code
);

    localparam logic [ALUC_W-1:0] ALUC_LAST = ALUC_W'(15);

    logic [ALUC_W-1:0] aluc_mem_r [2];
    logic [XLEN-1:0]   num1_mem_r [2];
    logic [XLEN-1:0]   num2_mem_r [2];
    logic [RD_W-1:0]   rd_mem_r   [2];
    logic              wr_ptr_r;
    logic              rd_ptr_r;
    logic [1:0]        count_r;
    logic              out_valid_r;
    logic [XLEN-1:0]   out_result_r;
    logic [RD_W-1:0]   out_rd_r;
    logic              abort_r;
    logic [ALUC_W-1:0] abort_code_r;

    logic              nonempty_s;
    logic [ALUC_W-1:0] head_aluc_s;
    logic [XLEN-1:0]   head_num1_s;
    logic [XLEN-1:0]   head_num2_s;
    logic [RD_W-1:0]   head_rd_s;
    logic              head_illegal_s;
    logic              free_s;
    logic              enq_s;
    logic              deq_legal_s;
    logic              deq_illegal_s;
    logic              deq_s;

    // Head decode and handshake qualification; in_ready depends only on registered count
    always_comb begin
        nonempty_s     = (count_r != 2'd0);
        head_aluc_s    = aluc_mem_r[rd_ptr_r];
        head_num1_s    = num1_mem_r[rd_ptr_r];
        head_num2_s    = num2_mem_r[rd_ptr_r];
        head_rd_s      = rd_mem_r[rd_ptr_r];
        head_illegal_s = (head_aluc_s > ALUC_LAST);
        in_ready       = (count_r != 2'd2);
        free_s         = !out_valid_r || out_ready;
        enq_s          = in_valid && in_ready;
        deq_legal_s    = nonempty_s && !head_illegal_s && free_s;
        deq_illegal_s  = nonempty_s && head_illegal_s;
        deq_s          = deq_legal_s || deq_illegal_s;
    end

    // Empty FIFO presents ADD 0+0 so the ALU never sees stale operands
    always_comb begin
        if (nonempty_s) begin
            alu_aluc = head_aluc_s;
            alu_num1 = head_num1_s;
            alu_num2 = head_num2_s;
        end else begin
            alu_aluc = {ALUC_W{1'b0}};
            alu_num1 = {XLEN{1'b0}};
            alu_num2 = {XLEN{1'b0}};
        end
    end

    // FIFO storage write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                aluc_mem_r[i] <= {ALUC_W{1'b0}};
                num1_mem_r[i] <= {XLEN{1'b0}};
                num2_mem_r[i] <= {XLEN{1'b0}};
                rd_mem_r[i]   <= {RD_W{1'b0}};
            end
        end else if (!flush && enq_s) begin
            aluc_mem_r[wr_ptr_r] <= in_aluc;
            num1_mem_r[wr_ptr_r] <= in_num1;
            num2_mem_r[wr_ptr_r] <= in_num2;
            rd_mem_r[wr_ptr_r]   <= in_rd;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (flush) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (enq_s) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (deq_s) rd_ptr_r <= rd_ptr_r + 1'b1;
            case ({enq_s, deq_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Result register towards writeback; an illegal dequeue leaves it untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            out_result_r <= {XLEN{1'b0}};
            out_rd_r     <= {RD_W{1'b0}};
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (deq_legal_s) begin
            out_valid_r  <= 1'b1;
            out_result_r <= alu_result;
            out_rd_r     <= head_rd_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Abort pulse one cycle after an illegal op leaves the FIFO; the code is sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abort_r      <= 1'b0;
            abort_code_r <= {ALUC_W{1'b0}};
        end else if (flush) begin
            abort_r <= 1'b0;
        end else begin
            abort_r <= deq_illegal_s;
            if (deq_illegal_s) abort_code_r <= head_aluc_s;
        end
    end

    assign out_valid  = out_valid_r;
    assign out_result = out_result_r;
    assign out_rd     = out_rd_r;
    assign abort      = abort_r;
    assign abort_code = abort_code_r;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: the bench plays the ALU and checks outputs after each edge,
// finishing with a random valid/ready run against a scoreboard queue.
module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_aluc;
    logic [31:0] in_num1;
    logic [31:0] in_num2;
    logic [4:0]  in_rd;
    logic [4:0]  alu_aluc;
    logic [31:0] alu_num1;
    logic [31:0] alu_num2;
    logic [31:0] alu_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        abort;
    logic [4:0]  abort_code;

    int checks;
    int errors;
    logic [36:0] exp_q [$];

    alu_issue dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_aluc(in_aluc),
        .in_num1(in_num1), .in_num2(in_num2), .in_rd(in_rd),
        .alu_aluc(alu_aluc), .alu_num1(alu_num1), .alu_num2(alu_num2),
        .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd),
        .abort(abort), .abort_code(abort_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU behaviour, also used as the stand-in ALU driving alu_result
    function automatic logic [31:0] alu_f(input logic [4:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
        case (c)
            5'd0, 5'd14, 5'd15: alu_f = a + b;
            5'd1:  alu_f = a - b;
            5'd2:  alu_f = a << b[4:0];
            5'd3:  alu_f = a ^ b;
            5'd4:  alu_f = a >> b[4:0];
            5'd5:  alu_f = $unsigned($signed(a) >>> b[4:0]);
            5'd6:  alu_f = a | b;
            5'd7:  alu_f = a & b;
            5'd8:  alu_f = {31'd0, a == b};
            5'd9:  alu_f = {31'd0, a != b};
            5'd10: alu_f = {31'd0, $signed(a) < $signed(b)};
            5'd11: alu_f = {31'd0, $signed(a) >= $signed(b)};
            5'd12: alu_f = {31'd0, a < b};
            5'd13: alu_f = {31'd0, a >= b};
            default: alu_f = 32'hDEAD_BEEF;
        endcase
    endfunction

    assign alu_result = alu_f(alu_aluc, alu_num1, alu_num2);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] r);
        in_valid = v;
        in_aluc  = c;
        in_num1  = a;
        in_num2  = b;
        in_rd    = r;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
        chk("rst_abort", {31'd0, abort}, 32'd0);
        chk("rst_abort_code", {27'd0, abort_code}, 32'd0);
        chk("rst_alu_num1", alu_num1, 32'd0);
        rst_n = 1'b1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();

        // back-to-back ADD and SUB with out_ready held high
        out_ready = 1'b1;
        drive(1'b1, 5'd0, 32'd5, 32'd7, 5'd3);
        tick();
        chk("t1_latency", {31'd0, out_valid}, 32'd0);
        drive(1'b1, 5'd1, 32'd3, 32'd9, 5'd4);
        tick();
        chk("t1_add_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_add_result", out_result, 32'd12);
        chk("t1_add_rd", {27'd0, out_rd}, 32'd3);
        drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
        tick();
        chk("t1_sub_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_sub_result", out_result, 32'hFFFF_FFFA);
        chk("t1_sub_rd", {27'd0, out_rd}, 32'd4);
        tick();
        chk("t1_idle", {31'd0, out_valid}, 32'd0);

        // writeback stall: FIFO fills, first result held, then drains in order
        out_ready = 1'b0;
        drive(1'b1, 5'd0, 32'd1, 32'd1, 5'd1);
        tick();
        drive(1'b1, 5'd3, 32'hF0, 32'hFF, 5'd2);
        tick();
        chk("t2_first_valid", {31'd0, out_valid}, 32'd1);
        drive(1'b1, 5'd6, 32'h10, 32'h01, 5'd3);
        tick();
        chk("t2_full_ready", {31'd0, in_ready}, 32'd0);
        drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
        tick();
        chk("t2_hold_result", out_result, 32'd2);
        chk("t2_hold_rd", {27'd0, out_rd}, 32'd1);
        chk("t2_hold_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        tick();
        chk("t2_second_result", out_result, 32'h0F);
        chk("t2_second_rd", {27'd0, out_rd}, 32'd2);
        tick();
        chk("t2_third_result", out_result, 32'h11);
        chk("t2_third_rd", {27'd0, out_rd}, 32'd3);
        tick();
        chk("t2_drained", {31'd0, out_valid}, 32'd0);

        // illegal code followed by SLL
        drive(1'b1, 5'd20, 32'd99, 32'd99, 5'd7);
        tick();
        drive(1'b1, 5'd2, 32'd1, 32'd4, 5'd8);
        tick();
        chk("t3_abort", {31'd0, abort}, 32'd1);
        chk("t3_abort_code", {27'd0, abort_code}, 32'd20);
        chk("t3_no_valid", {31'd0, out_valid}, 32'd0);
        drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
        tick();
        chk("t3_abort_pulse", {31'd0, abort}, 32'd0);
        chk("t3_sll_valid", {31'd0, out_valid}, 32'd1);
        chk("t3_sll_result", out_result, 32'd16);
        chk("t3_sll_rd", {27'd0, out_rd}, 32'd8);
        chk("t3_code_held", {27'd0, abort_code}, 32'd20);
        tick();

        // flush with the FIFO full and a result pending
        out_ready = 1'b0;
        drive(1'b1, 5'd0, 32'd10, 32'd10, 5'd9);
        tick();
        drive(1'b1, 5'd0, 32'd11, 32'd11, 5'd10);
        tick();
        drive(1'b1, 5'd0, 32'd12, 32'd12, 5'd11);
        tick();
        chk("t4_full", {31'd0, in_ready}, 32'd0);
        chk("t4_pending", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_flush_valid", {31'd0, out_valid}, 32'd0);
        chk("t4_flush_ready", {31'd0, in_ready}, 32'd1);
        chk("t4_flush_empty", alu_num1, 32'd0);
        chk("t4_code_kept", {27'd0, abort_code}, 32'd20);
        drive(1'b1, 5'd0, 32'd13, 32'd13, 5'd12);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
        chk("t4_flush_drops_op", alu_num1, 32'd0);
        tick();
        chk("t4_no_stale", {31'd0, out_valid}, 32'd0);

        // asynchronous reset with a result pending and abort high
        out_ready = 1'b0;
        drive(1'b1, 5'd0, 32'd2, 32'd2, 5'd1);
        tick();
        drive(1'b1, 5'd31, 32'd0, 32'd0, 5'd2);
        tick();
        drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
        tick();
        chk("t5_pre_abort", {31'd0, abort}, 32'd1);
        chk("t5_pre_code", {27'd0, abort_code}, 32'd31);
        chk("t5_pre_valid", {31'd0, out_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("t5_rst_abort", {31'd0, abort}, 32'd0);
        chk("t5_rst_code", {27'd0, abort_code}, 32'd0);
        chk("t5_rst_result", out_result, 32'd0);
        #1 rst_n = 1'b1;
        chk("t5_rel_ready", {31'd0, in_ready}, 32'd1);
        tick();

        // random valid/ready traffic against the scoreboard
        for (int i = 0; i < 3000; i++) begin
            logic [4:0]  c;
            logic [31:0] a;
            logic [31:0] b;
            logic [4:0]  r;
            c = 5'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            r = 5'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 1)), c, a, b, r);
            out_ready = 1'($urandom_range(0, 3) != 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("t6_spurious", {31'd0, out_valid}, 32'd0);
                end else begin
                    chk("t6_result", out_result, exp_q[0][36:5]);
                    chk("t6_rd", {27'd0, out_rd}, {27'd0, exp_q[0][4:0]});
                    void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back({alu_f(c, a, b), r});
            tick();
        end
        drive(1'b0, 5'd0, 32'd0, 32'd0, 5'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("t6_drain_spurious", {31'd0, out_valid}, 32'd0);
                end else begin
                    chk("t6_drain_result", out_result, exp_q[0][36:5]);
                    chk("t6_drain_rd", {27'd0, out_rd}, {27'd0, exp_q[0][4:0]});
                    void'(exp_q.pop_front());
                end
            end
            tick();
        end
        chk("t6_all_delivered", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
